// File: rtl/call_return_stack.sv
// Return-address stack: LIFO of ADDR_W-bit return addresses with full/empty, sticky errors and flush.
// Optional build macro RAS_WRAP_EN: circular storage, so a push while full overwrites the oldest entry.
module call_return_stack #(
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DEPTH   = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(8'hFF)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  output logic [ADDR_W-1:0]        pop_addr_o,
  output logic                     pop_valid_o,
  output logic [ADDR_W-1:0]        top_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ADDR_W-1:0]        sp_mirror_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              new_ovf, new_unf;
  logic              mem_we;
  logic [PW-1:0]     mem_widx;
  logic [PW-1:0]     tail_idx, top_idx;
  logic              full, empty;

`ifdef RAS_WRAP_EN
  logic [PW-1:0]     base_q, base_d;
  // Logical slot k lives at base+k; when full, tail_idx wraps onto the oldest entry.
  assign tail_idx = base_q + count_q[PW-1:0];
`else
  assign tail_idx = count_q[PW-1:0];
`endif
  assign top_idx = tail_idx - PW'(1);

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign pop_addr_o  = pop_addr_q;
  assign pop_valid_o = pop_valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign top_addr_o  = empty ? '0 : mem_q[top_idx];
  assign sp_mirror_o = SP_INIT - ADDR_W'(count_q);

  always_comb begin
    count_d     = count_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = tail_idx;
    new_ovf     = 1'b0;
    new_unf     = 1'b0;
`ifdef RAS_WRAP_EN
    base_d      = base_q;
`endif
    if (flush_i) begin
      count_d = '0;
`ifdef RAS_WRAP_EN
      base_d  = '0;
`endif
    end else if (push_i && pop_i) begin
      if (empty) begin
        new_unf = 1'b1;
        mem_we  = 1'b1;
        count_d = CW'(1);
      end else begin
        // Return the old top and replace it in place; depth is unchanged.
        pop_addr_d  = mem_q[top_idx];
        pop_valid_d = 1'b1;
        mem_we      = 1'b1;
        mem_widx    = top_idx;
      end
    end else if (push_i) begin
      if (!full) begin
        mem_we  = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        new_ovf = 1'b1;
`ifdef RAS_WRAP_EN
        mem_we  = 1'b1;
        base_d  = base_q + PW'(1);
`endif
      end
    end else if (pop_i) begin
      if (empty) begin
        new_unf = 1'b1;
      end else begin
        pop_addr_d  = mem_q[top_idx];
        pop_valid_d = 1'b1;
        count_d     = count_q - CW'(1);
      end
    end
    overflow_d  = (overflow_q  & ~clr_err_i) | new_ovf;
    underflow_d = (underflow_q & ~clr_err_i) | new_unf;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      pop_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef RAS_WRAP_EN
      base_q      <= '0;
`endif
    end else begin
      count_q     <= count_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef RAS_WRAP_EN
      base_q      <= base_d;
`endif
    end
  end

  // Entry storage carries no reset; contents only matter below count.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem_q[mem_widx] <= push_addr_i;
    end
  end

endmodule
